// File: rtl/trace_pkg.sv
// Shared types and character decode for the trace player: end-of-trace modes
// and the mapping from trace characters to waveform levels.
package trace_pkg;

   typedef enum logic [1:0] {
      TRACE_HOLD    = 2'd0,
      TRACE_WRAP    = 2'd1,
      TRACE_ONESHOT = 2'd2
   } trace_mode_e;

   localparam logic [7:0] CH_DASH  = "-";
   localparam logic [7:0] CH_UNDER = "_";
   localparam logic [7:0] CH_ONE   = "1";

   function automatic logic trace_char_bit(input logic [7:0] ch);
      return (ch == CH_DASH) || (ch == CH_ONE);
   endfunction

   // Mode 3 and anything else unknown fall back to HOLD.
   function automatic trace_mode_e trace_mode_of(input int mode);
      case (mode)
         1:       return TRACE_WRAP;
         2:       return TRACE_ONESHOT;
         default: return TRACE_HOLD;
      endcase
   endfunction

endpackage

// File: rtl/trace_index.sv
// Step counter for the trace player: tracks the current step, end-of-trace
// flags and a saturating count of completed passes.
module trace_index
   import trace_pkg::*;
#(
   parameter int LEN  = 32,
   parameter int MODE = 0,
   parameter int CW   = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   restart,
   output logic [$clog2(LEN)-1:0] step,
   output logic                   last,
   output logic                   finished,
   output logic [CW-1:0]          passes
);

   localparam int SW = $clog2(LEN);
   localparam logic [SW-1:0] TLAST = SW'(LEN - 1);
   localparam trace_mode_e MD = trace_mode_of(MODE);

   logic held;
   logic fin;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // held marks the first arrival at the last step so HOLD/ONESHOT count one pass only.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         step   <= '0;
         held   <= 1'b0;
         fin    <= 1'b0;
         passes <= '0;
      end else if (restart) begin
         step <= '0;
         held <= 1'b0;
         fin  <= 1'b0;
      end else if (enable) begin
         if (step != TLAST) begin
            step <= step + 1'b1;
         end else if (MD == TRACE_WRAP) begin
            step   <= '0;
            passes <= sat_inc(passes);
         end else if (!held) begin
            held   <= 1'b1;
            passes <= sat_inc(passes);
            if (MD == TRACE_ONESHOT) fin <= 1'b1;
         end
      end
   end

   assign finished = (MD == TRACE_ONESHOT) ? fin : 1'b0;
   assign last     = (step == TLAST) && !finished;

endmodule

// File: rtl/trace_player.sv
// Plays NCH single-bit waveforms stored as ASCII strings, one character per
// clock; the column for each step is decoded at elaboration time.
module trace_player
   import trace_pkg::*;
#(
   parameter int                    NCH    = 4,
   parameter int                    LEN    = 32,
   parameter logic [8*NCH*LEN-1:0]  TRACES = {(NCH*LEN){8'h5F}},
   parameter int                    MODE   = 0,
   parameter int                    CW     = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   restart,
   output logic [NCH-1:0]         out,
   output logic [$clog2(LEN)-1:0] step,
   output logic                   last,
   output logic                   finished,
   output logic [CW-1:0]          passes
);

   logic [NCH-1:0] col [LEN];

   // Step 0 of each channel is its leftmost (most significant) character.
   function automatic logic [NCH-1:0] column(input int t);
      logic [NCH-1:0] v;
      v = '0;
      for (int c = 0; c < NCH; c++) begin
         v[c] = trace_char_bit(TRACES[8*(LEN*c + LEN - 1 - t) +: 8]);
      end
      return v;
   endfunction

   for (genvar t = 0; t < LEN; t++) begin : g_col
      assign col[t] = column(t);
   end

   trace_index #(
      .LEN  (LEN),
      .MODE (MODE),
      .CW   (CW)
   ) u_index (
      .clock    (clock),
      .reset    (reset),
      .enable   (enable),
      .restart  (restart),
      .step     (step),
      .last     (last),
      .finished (finished),
      .passes   (passes)
   );

   assign out = finished ? '0 : col[step];

endmodule
